// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table tester.
// Holds the FSM encoding and the binary-to-Gray mapping.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_V = 2'd1,
      LAST   = 2'd2,
      FIN    = 2'd3
   } state_t;

   // Wide enough for the largest supported idx (N_IN=8 -> 9 bits).
   localparam int GW = 9;

   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/tt_vec_seq.sv
// Vector sequencer: idx and hold counters, binary/Gray mapping.
// window_last marks the sample cycle of each hold window.
module tt_vec_seq
   import tt_pkg::*;
#(
   parameter int N_IN = 3,
   parameter int HOLD = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            gray_in,
   input  logic            run,
   output logic [N_IN-1:0] vec,
   output logic            window_last,
   output logic            idx_last
);

   localparam int CW = $clog2(HOLD);
   localparam logic [N_IN:0] IDX_END = (N_IN+1)'((1 << N_IN) - 1);
   localparam logic [CW-1:0] CNT_END = CW'(HOLD - 1);

   logic [N_IN:0] idx;
   logic [N_IN:0] idx_inc;
   logic [CW-1:0] cnt;
   logic          gray_q;
   logic          lead;

   function automatic logic [N_IN-1:0] map_vec(
      input logic [N_IN:0] i,
      input logic          g
   );
      logic [GW-1:0] w;
      w = GW'(i);
      return g ? N_IN'(bin2gray(w)) : N_IN'(w);
   endfunction

   assign idx_inc     = idx + 1'b1;
   assign idx_last    = (idx == IDX_END);
   assign window_last = run && !lead && (cnt == CNT_END);

   // lead delays the first vector by one edge after the start is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         cnt    <= '0;
         gray_q <= 1'b0;
         lead   <= 1'b0;
         vec    <= '0;
      end else if (load) begin
         idx    <= '0;
         cnt    <= '0;
         gray_q <= gray_in;
         lead   <= 1'b1;
      end else if (run) begin
         if (lead) begin
            lead <= 1'b0;
            vec  <= map_vec(idx, gray_q);
         end else if (cnt == CNT_END) begin
            cnt <= '0;
            if (!idx_last) begin
               idx <= idx_inc;
               vec <= map_vec(idx_inc, gray_q);
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/truth_table_tester.sv
// Exhaustive stimulus generator and response checker for an
// N-input combinational function against a parameter truth table.
module truth_table_tester
   import tt_pkg::*;
#(
   parameter int                          N_IN     = 3,
   parameter int                          N_OUT    = 1,
   parameter int                          HOLD     = 10,
   parameter logic [N_OUT*(1<<N_IN)-1:0] EXPECTED = 8'b1110_1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             gray_mode,
   output logic [N_IN-1:0]  vec_out,
   input  logic [N_OUT-1:0] resp_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    err_count,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             first_err_valid
);

   state_t state;
   state_t state_nxt;

   logic             load;
   logic             run;
   logic             window_last;
   logic             idx_last;
   logic [N_OUT-1:0] exp_resp;
   logic             mismatch;
   logic [N_IN:0]    err_nxt;

   tt_vec_seq #(
      .N_IN (N_IN),
      .HOLD (HOLD)
   ) u_seq (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .gray_in     (gray_mode),
      .run         (run),
      .vec         (vec_out),
      .window_last (window_last),
      .idx_last    (idx_last)
   );

   // Table lookup is by the driven vector value, not by idx.
   assign exp_resp = EXPECTED[int'(vec_out)*N_OUT +: N_OUT];
   assign mismatch = (resp_in != exp_resp);
   assign err_nxt  = err_count + (N_IN+1)'(mismatch);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = HOLD_V;
         HOLD_V:  if (window_last && idx_last) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load = 1'b0;
      run  = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         IDLE:    load = start;
         HOLD_V: begin
            run  = 1'b1;
            busy = 1'b1;
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
      end else if (load) begin
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
      end else if (window_last) begin
         err_count <= err_nxt;
         if (mismatch && !first_err_valid) begin
            first_err_vec   <= vec_out;
            first_err_valid <= 1'b1;
         end
         if (idx_last) pass <= (err_nxt == '0);
      end
   end

endmodule

// File: tb/tb_truth_table_tester.sv
// Bench for truth_table_tester: 3-input majority and a 4-in/2-out
// table with one deliberately wrong entry.
module tb_truth_table_tester;

   function automatic logic maj(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   function automatic logic [1:0] f4(input logic [3:0] v);
      return {v[1] & v[0], ^v};
   endfunction

   function automatic logic [31:0] mk_tbl();
      logic [31:0] t;
      t = '0;
      for (int v = 0; v < 16; v++) t[v*2 +: 2] = f4(4'(v));
      t[18] = ~t[18];
      return t;
   endfunction

   localparam logic [31:0] TBL4 = mk_tbl();

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       start3 = 1'b0;
   logic       gray3  = 1'b0;
   logic [2:0] vec3;
   logic       resp3;
   logic       busy3, done3, pass3, fev3;
   logic [3:0] err3;
   logic [2:0] fe3;
   logic       force_one = 1'b0;

   logic       start4 = 1'b0;
   logic [3:0] vec4;
   logic [1:0] resp4;
   logic       busy4, done4, pass4, fev4;
   logic [4:0] err4;
   logic [3:0] fe4;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   assign resp3 = force_one ? 1'b1 : maj(vec3);
   assign resp4 = f4(vec4);

   truth_table_tester #(
      .N_IN (3), .N_OUT (1), .HOLD (10), .EXPECTED (8'hE8)
   ) dut3 (
      .clk (clk), .rst (rst), .start (start3), .gray_mode (gray3),
      .vec_out (vec3), .resp_in (resp3), .busy (busy3), .done (done3),
      .pass (pass3), .err_count (err3), .first_err_vec (fe3),
      .first_err_valid (fev3)
   );

   truth_table_tester #(
      .N_IN (4), .N_OUT (2), .HOLD (2), .EXPECTED (TBL4)
   ) dut4 (
      .clk (clk), .rst (rst), .start (start4), .gray_mode (1'b0),
      .vec_out (vec4), .resp_in (resp4), .busy (busy4), .done (done4),
      .pass (pass4), .err_count (err4), .first_err_vec (fe4),
      .first_err_valid (fev4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One run of dut3; returns early after a mid-run reset.
   task automatic run3(input logic g, input logic frc,
                       input int rst_at, input bit pulses);
      int         c;
      bit         seen;
      logic [3:0] ev;
      logic [3:0] last;
      force_one = frc;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         ev = g ? 4'(i ^ (i >> 1)) : 4'(i);
         exp_q.push_back(ev);
         last = ev;
      end
      gray3  = g;
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      c = 0;
      seen = 0;
      while (c < 90) begin
         start3 = pulses && (c == 20 || c == 50 || c == 81);
         rst    = (c == rst_at);
         step();
         c++;
         rst = 1'b0;
         if (c == rst_at + 1) begin
            checks++;
            if ({vec3, busy3, done3, pass3, err3, fe3, fev3} !== '0)
               $display("FAIL mid_reset outs=%b required all zero",
                        {vec3, busy3, done3, pass3, err3, fe3, fev3});
            if ({vec3, busy3, done3, pass3, err3, fe3, fev3} !== '0)
               errors++;
            exp_q.delete();
            return;
         end
         if (c % 10 == 1 && exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            checks++;
            if ({1'b0, vec3} !== ev) begin
               errors++;
               $display("FAIL vec c=%0d got %0d required %0d", c, vec3, ev);
            end
         end
         if (c == 1) begin
            checks++;
            if (busy3 !== 1'b1) begin
               errors++;
               $display("FAIL busy_start got %b required 1", busy3);
            end
         end
         if (done3 === 1'b1) begin
            checks++;
            if (c != 81 || seen) begin
               errors++;
               $display("FAIL done_cycle got %0d required 81", c);
            end
            seen = 1;
         end
         if (c == 82 || c == 83) begin
            checks++;
            if (busy3 !== 1'b0 || {1'b0, vec3} !== last) begin
               errors++;
               $display("FAIL idle_after c=%0d busy %b vec %0d required 0 %0d",
                        c, busy3, vec3, last);
            end
         end
         if (c == 83) break;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout no done within budget");
      end
   endtask

   task automatic chk3(input string nm, input logic p, input logic [3:0] e,
                       input logic [2:0] fv, input logic fval);
      checks++;
      if ({pass3, err3, fe3, fev3} !== {p, e, fv, fval}) begin
         errors++;
         $display("FAIL %s pass/err/fev/fvalid got %b/%0d/%0d/%b required %b/%0d/%0d/%b",
                  nm, pass3, err3, fe3, fev3, p, e, fv, fval);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({vec3, busy3, done3, pass3, err3, fe3, fev3} !== '0) begin
         errors++;
         $display("FAIL reset3 got %b required 0",
                  {vec3, busy3, done3, pass3, err3, fe3, fev3});
      end
      checks++;
      if ({vec4, busy4, done4, pass4, err4, fe4, fev4} !== '0) begin
         errors++;
         $display("FAIL reset4 got %b required 0",
                  {vec4, busy4, done4, pass4, err4, fe4, fev4});
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_binary();
      run3(1'b0, 1'b0, -1, 1'b0);
      chk3("binary", 1'b1, 4'd0, 3'd0, 1'b0);
   endtask

   task automatic test_forced();
      run3(1'b0, 1'b1, -1, 1'b0);
      chk3("forced", 1'b0, 4'd4, 3'd0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run3(1'b0, 1'b0, -1, 1'b1);
      chk3("restart", 1'b1, 4'd0, 3'd0, 1'b0);
   endtask

   task automatic test_gray();
      run3(1'b1, 1'b0, -1, 1'b0);
      chk3("gray", 1'b1, 4'd0, 3'd0, 1'b0);
   endtask

   task automatic test_mid_reset();
      run3(1'b0, 1'b1, 35, 1'b0);
      step();
      run3(1'b0, 1'b0, -1, 1'b0);
      chk3("after_reset", 1'b1, 4'd0, 3'd0, 1'b0);
   endtask

   task automatic test_wide();
      int         c;
      bit         seen;
      logic [3:0] ev;
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      c = 0;
      seen = 0;
      while (c < 40) begin
         step();
         c++;
         if (c % 2 == 1 && exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            checks++;
            if (vec4 !== ev) begin
               errors++;
               $display("FAIL vec4 c=%0d got %0d required %0d", c, vec4, ev);
            end
         end
         if (done4 === 1'b1) begin
            checks++;
            if (c != 33 || seen) begin
               errors++;
               $display("FAIL done4_cycle got %0d required 33", c);
            end
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done4_timeout no done within budget");
      end
      checks++;
      if ({pass4, err4, fe4, fev4} !== {1'b0, 5'd1, 4'd9, 1'b1}) begin
         errors++;
         $display("FAIL wide pass/err/fev/fvalid got %b/%0d/%0d/%b required 0/1/9/1",
                  pass4, err4, fe4, fev4);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_binary();
      test_forced();
      test_back_to_back();
      test_gray();
      test_mid_reset();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_tester.md
Name: truth_table_tester

Overview:
- Synthesizable, parametrised exhaustive stimulus generator and response checker for N-input combinational functions.
- Replaces hand-written per-vector benches such as the 3-input function benches.
- Sequences all 2^N_IN input vectors in binary or Gray order and holds each vector for HOLD cycles.
- Samples the DUT response on the last hold cycle and compares it against a parameter truth table.
- Reports error count, first failing vector and pass/fail.

Parameters:
- N_IN, 3, number of function inputs (1..8).
- N_OUT, 1, number of function outputs checked (1..8).
- HOLD, 10, cycles each vector is held (>=2); the response is sampled on the last cycle.
- EXPECTED, 8'b1110_1000, expected table, N_OUT*2^N_IN bits; the slice [v*N_OUT +: N_OUT] is the expected response for input value v.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only when not busy.
- gray_mode  in  1  sampled with start; 1 = Gray-code vector order, 0 = ascending binary.
- vec_out  out  N_IN  stimulus vector driven to the DUT inputs.
- resp_in  in  N_OUT  DUT response.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last vector has been checked.
- pass  out  1  valid from done until the next accepted start; 1 when err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors; saturation is impossible because the maximum is 2^N_IN.
- first_err_vec  out  N_IN  vec_out value of the first mismatch.
- first_err_valid  out  1  set at the first mismatch; cleared on start or rst.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything and may occur mid-run. Reset values:
  - state=IDLE; vec_out=0; busy=0; done=0; pass=0; err_count=0; first_err_vec=0; first_err_valid=0.
- FSM states: IDLE, HOLD_V, LAST, FIN.
  - IDLE: on start=1, latch gray_mode, clear idx, hold counter, err_count, first_err_* and pass, then go to HOLD_V. vec_out for idx 0 equals 0 in both modes.
  - HOLD_V: hold counter counts 0..HOLD-1. At count HOLD-1, sample resp_in and compare it against the EXPECTED slice indexed by vec_out (the actual vector value, not idx).
    - On mismatch: err_count+1; if first_err_valid=0, capture first_err_vec=vec_out and set first_err_valid.
    - If idx==2^N_IN-1, go to FIN. Otherwise idx+1, update vec_out, reset the counter and stay in HOLD_V.
  - LAST: unused encoding reserved; any illegal state recovers to IDLE.
  - FIN: done=1 for exactly one cycle; pass=(err_count==0 including the final compare); busy=0; return to IDLE.
- vec_out is registered: vec_out = idx in binary mode, idx ^ (idx>>1) in Gray mode. It changes on the clk edge that starts each hold window and is stable for exactly HOLD cycles.
- Latency: start accepted at edge 0. First vec_out edge is 1. Done is asserted in cycle 2^N_IN*HOLD+1 after start.
- start while busy is ignored with no side effect. start in the FIN cycle is ignored. start in IDLE after a finished run restarts and clears the results.
- vec_out is held at its last value after the run until the next start or rst.
- The idx counter is N_IN+1 bits wide so the terminal compare at 2^N_IN-1 does not wrap. The hold counter is $clog2(HOLD) bits wide.
- resp_in is compared with !==-free synthesizable equality; the DUT must settle within HOLD-1 cycles.

Decomposition:
- Package tt_pkg holds the state enum (IDLE, HOLD_V, LAST, FIN) and the function bin2gray(N).
- One sub-module, tt_vec_seq, implements the idx/hold counters and the binary/Gray vector generator with a "window_last" strobe.
- The checker and result registers stay in the top module.

Test Plan:
- Majority function DUT (N_IN=3, HOLD=10, EXPECTED=8'hE8), binary order, start at t0 -> vec_out steps 0,1..7 every 10 cycles; done pulse at cycle 81; pass=1; err_count=0; first_err_valid=0.
- Same setup with the DUT output forced to 1 -> err_count=4 (vectors 0,1,2,4); first_err_vec=0; pass=0.
- gray_mode=1 with a correct DUT -> vec_out sequence 0,1,3,2,6,7,5,4; pass=1; the compare is indexed by the vector value.
- rst asserted at cycle 35 mid-run -> the next cycle shows all outputs zero and state IDLE. A new start gives a full 81-cycle run with clean results.
- start pulsed at cycles 20 and 50 during a run -> ignored; done still at cycle 81; start in the FIN cycle is ignored. start after done restarts and clears err_count.
- N_IN=4, N_OUT=2, HOLD=2 with XOR/AND table and one wrong entry at v=9 -> err_count=1; first_err_vec=4'd9; done at cycle 33.
